// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle control FSM.
//   - state_e      : FSM state encoding (also exported on state_dbg)
//   - op_class_e   : opcode classes produced by mc_opcode_class
//   - ctrl_t       : bundle of datapath control outputs
//   - OP_*         : fixed opcodes for branch/jump/memory instructions
//   - ALUB_*/PC_*  : encodings of the alu_src_b and pc_src selects
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR, CLS_J, CLS_ILL
  } op_class_e;

  localparam logic [5:0] OP_BEQ = 6'h20;
  localparam logic [5:0] OP_BNE = 6'h21;
  localparam logic [5:0] OP_J   = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h30;
  localparam logic [5:0] OP_SW  = 6'h31;

  localparam logic [1:0] ALUB_REG = 2'd0;
  localparam logic [1:0] ALUB_ONE = 2'd1;
  localparam logic [1:0] ALUB_IMM = 2'd2;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  typedef struct packed {
    logic       sel_ins;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_write;
    logic       mem_to_reg;
    logic       beq;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: connection between the control FSM and the datapath side.
//   Inputs to the controller : run, opcode[5:0], mem_ready
//   Outputs of the controller: datapath controls, pc_write, illegal,
//                              ins_count[CNT_W-1:0], state_dbg[3:0]
//   modport master : the controller (drives the controls)
//   modport slave  : the datapath / CPU top (drives run, opcode, mem_ready)
interface multicycle_control_if #(
  parameter int CNT_W = 32
) ();
  logic             run;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             sel_ins;
  logic             reg_write;
  logic             reg_dst;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             mem_write;
  logic             mem_to_reg;
  logic             beq;
  logic [1:0]       pc_src;
  logic             pc_write;
  logic             illegal;
  logic [CNT_W-1:0] ins_count;
  logic [3:0]       state_dbg;

  modport master (
    input  run, opcode, mem_ready,
    output sel_ins, reg_write, reg_dst, alu_src_a, alu_src_b, mem_write,
           mem_to_reg, beq, pc_src, pc_write, illegal, ins_count, state_dbg
  );

  modport slave (
    output run, opcode, mem_ready,
    input  sel_ins, reg_write, reg_dst, alu_src_a, alu_src_b, mem_write,
           mem_to_reg, beq, pc_src, pc_write, illegal, ins_count, state_dbg
  );
endinterface

// File: rtl/mc_opcode_class.sv
// mc_opcode_class: combinational opcode-to-class decoder.
//   i_opcode[5:0] : decoded instruction opcode
//   o_class       : R, I, LW, SW, BR, J or ILL
module mc_opcode_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output op_class_e  o_class
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    o_class = CLS_ILL;
    if (i_opcode[5:4] == 2'b00) begin
      o_class = CLS_R;
    end else if (i_opcode[5:4] == 2'b01) begin
      o_class = CLS_I;
    end else begin
      case (i_opcode)
        OP_BEQ, OP_BNE: o_class = CLS_BR;
        OP_J:           o_class = CLS_J;
        OP_LW:          o_class = CLS_LW;
        OP_SW:          o_class = CLS_SW;
        default:        o_class = CLS_ILL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM sequencing the multicycle datapath.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : multicycle_control_if.master
//                in : run, opcode, mem_ready
//                out: sel_ins, reg_write, reg_dst, alu_src_a, alu_src_b,
//                     mem_write, mem_to_reg, beq, pc_src, pc_write,
//                     illegal, ins_count, state_dbg
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  state_e           r_state;
  state_e           w_next;
  op_class_e        w_class;
  op_class_e        r_class;
  ctrl_t            w_ctrl;
  logic             w_retire;
  logic [CNT_W-1:0] r_ins_count;

  mc_opcode_class u_class (
    .i_opcode (bus.opcode),
    .o_class  (w_class)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_class     <= CLS_R;
      r_ins_count <= '0;
    end else begin
      r_state <= w_next;
      // Class is latched at DECODE so ALU_WB and MEM_ADDR do not depend on
      // the opcode staying stable afterwards.
      if (r_state == S_DECODE) r_class <= w_class;
      if (w_retire)            r_ins_count <= r_ins_count + 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ctrl   = '0;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.run) begin
          w_ctrl.pc_write  = 1'b1;
          w_ctrl.pc_src    = PC_INC;
          w_ctrl.alu_src_b = ALUB_ONE;
          w_next           = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_class)
          CLS_R:         w_next = S_EXEC_R;
          CLS_I:         w_next = S_EXEC_I;
          CLS_LW, CLS_SW: w_next = S_MEM_ADDR;
          CLS_BR:        w_next = S_BRANCH;
          CLS_J:         w_next = S_JUMP;
          default: begin
            w_ctrl.illegal = 1'b1;
            w_next         = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUB_REG;
        w_next           = S_ALU_WB;
      end
      S_EXEC_I: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUB_IMM;
        w_next           = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = (r_class == CLS_R);
        w_retire         = 1'b1;
        w_next           = S_FETCH;
      end
      S_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUB_IMM;
        w_next           = (r_class == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_ctrl.sel_ins = 1'b1;
        if (bus.mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_retire          = 1'b1;
        w_next            = S_FETCH;
      end
      S_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        if (bus.mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUB_REG;
        w_ctrl.beq       = ~bus.opcode[0];
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_src    = PC_BR;
        w_retire         = 1'b1;
        w_next           = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src   = PC_JMP;
        w_retire        = 1'b1;
        w_next          = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // FETCH decodes run combinationally, so without this gate a reset held
    // with run = 1 would still present a pc_write strobe.
    if (!rst_n) begin
      w_ctrl   = '0;
      w_retire = 1'b0;
    end
  end

  assign bus.sel_ins    = w_ctrl.sel_ins;
  assign bus.reg_write  = w_ctrl.reg_write;
  assign bus.reg_dst    = w_ctrl.reg_dst;
  assign bus.alu_src_a  = w_ctrl.alu_src_a;
  assign bus.alu_src_b  = w_ctrl.alu_src_b;
  assign bus.mem_write  = w_ctrl.mem_write;
  assign bus.mem_to_reg = w_ctrl.mem_to_reg;
  assign bus.beq        = w_ctrl.beq;
  assign bus.pc_src     = w_ctrl.pc_src;
  assign bus.pc_write   = w_ctrl.pc_write;
  assign bus.illegal    = w_ctrl.illegal;
  assign bus.ins_count  = r_ins_count;
  assign bus.state_dbg  = r_state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the multicycle Datapath. Drives its control inputs: SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB, MemWrite, MemtoReg, BEQ and PCSrc.
- Adds a PC write strobe, a data-memory ready handshake, a run/idle gate, an illegal-opcode flag and a retired-instruction counter.
- Sits beside Datapath in the CPU top level. Its only datapath input is the decoded 6-bit opcode.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = fetch new instructions; 0 = idle in FETCH after the current instruction completes.
- opcode  in  6  OPcode field from instruction decoder.
- mem_ready  in  1  data memory accepted write / read data valid this cycle.
- sel_ins  out  1  IorD: 0 = PC, 1 = ALU output.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  1 = write Rd, 0 = write Rs field.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  0 = B, 1 = constant 1, 2 = IMM32.
- mem_write  out  1  data memory write enable.
- mem_to_reg  out  1  1 = write-back from memory data.
- beq  out  1  1 = BEQ condition, 0 = BNE condition.
- pc_src  out  2  0 = PC+1, 1 = branch target, 2 = jump.
- pc_write  out  1  PC load strobe.
- illegal  out  1  one-cycle pulse on undefined opcode.
- ins_count  out  CNT_W  retired instructions.
- state_dbg  out  4  current state encoding.

Behaviour:
- Opcode classes:
  - opcode[5:4] = 00: R-type ALU.
  - opcode[5:4] = 01: I-type ALU.
  - 0x20 BEQ, 0x21 BNE, 0x22 J.
  - 0x30 LW, 0x31 SW.
  - Anything else is illegal.
- States: FETCH(0), DECODE(1), EXEC_R(2), EXEC_I(3), ALU_WB(4), MEM_ADDR(5), MEM_RD(6), MEM_WB(7), MEM_WR(8), BRANCH(9), JUMP(10). All other encodings go to FETCH.
- Reset (rst_n low, asynchronous):
  - state = FETCH, ins_count = 0, all control outputs 0.
  - Reset mid-instruction abandons that instruction; no write strobe is issued after rst_n falls.
- Unlisted outputs are 0 in every state. Outputs decode combinationally from state, plus run in FETCH and mem_ready where noted.
- FETCH:
  - run = 1: pc_write = 1, pc_src = 0, alu_src_a = 0, alu_src_b = 1; go to DECODE.
  - run = 0: all outputs 0; stay in FETCH.
- DECODE: route on opcode class to EXEC_R, EXEC_I, MEM_ADDR, BRANCH or JUMP.
  - Illegal opcode: illegal = 1 for this cycle; go to FETCH; ins_count unchanged.
- EXEC_R: alu_src_a = 1, alu_src_b = 0; go to ALU_WB.
- EXEC_I: alu_src_a = 1, alu_src_b = 2; go to ALU_WB.
- ALU_WB: reg_write = 1, reg_dst = 1 for R-type and 0 for I-type (class is held in an internal register captured at DECODE); retire; go to FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2; go to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: sel_ins = 1. Stay while mem_ready = 0; go to MEM_WB when mem_ready = 1.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0; retire; go to FETCH.
- MEM_WR: mem_write = 1 held until the cycle mem_ready = 1; retire that cycle; go to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, beq = ~opcode[0], pc_write = 1, pc_src = 1; retire; go to FETCH.
- JUMP: pc_write = 1, pc_src = 2; retire; go to FETCH.
- Retire: ins_count increments by 1 on the clock edge leaving the retiring state; wraps from all-ones to 0.
- Latency in cycles, with mem_ready already high:
  - R/I-type 4, LW 5, SW 4, branch/jump 3, illegal 2.
  - Each wait cycle on mem_ready adds 1 to LW or SW.
- run falling mid-instruction: the instruction completes, then the FSM idles in FETCH. run is sampled only in FETCH.

Decomposition:
- Package mc_ctrl_pkg:
  - state localparams.
  - opcode constants OP_BEQ, OP_BNE, OP_J, OP_LW, OP_SW.
  - encodings ALUB_REG, ALUB_ONE, ALUB_IMM, PC_INC, PC_BR, PC_JMP.
- Sub-module mc_opcode_class: combinational opcode-to-class decoder (classes R, I, LW, SW, BR, J, ILL), used by DECODE.

Test Plan:
- Reset with run = 0, then rst_n released -> state_dbg = 0, every output 0, ins_count = 0 for 5 cycles.
- run = 1, opcode = 0x02 -> state sequence 0,1,2,4,0; pc_write only in FETCH; reg_write = 1 with reg_dst = 1 in state 4; ins_count = 1.
- opcode = 0x30, mem_ready low for 3 cycles -> state 6 held 4 cycles, then 7 with reg_write = 1 and mem_to_reg = 1; total 8 cycles; ins_count + 1.
- opcode = 0x31, mem_ready = 1 -> mem_write high exactly 1 cycle in state 8; reg_write never asserted.
- opcode = 0x21 -> BRANCH with beq = 0, pc_src = 1, pc_write = 1. opcode = 0x22 -> JUMP with pc_src = 2.
- opcode = 0x3F -> illegal pulse of 1 cycle, back to FETCH, ins_count unchanged. rst_n asserted during MEM_WR -> mem_write drops immediately and state = 0.
